// File: rtl/dport_sram_responder.sv
// dport_sram_responder: word SRAM behind a valid/ready data port, with optional access delay
// and an in-order response FIFO.
module dport_sram_responder #(
  parameter int unsigned C_MEM_DEPTH_X = 8,
  parameter logic [31:0] C_BASE_ADDR   = 32'h0,
  parameter int unsigned C_WAIT_CYCLES = 0,
  parameter int unsigned C_RSP_DEPTH_X = 1,
  parameter bit          C_USER_WR_EN  = 1'b1
) (
  input  logic        clk_i,
  input  logic        resetb_i,
  input  logic        clk_en_i,
  output logic        dreqready_o,
  input  logic        dreqvalid_i,
  input  logic [1:0]  dreqsize_i,
  input  logic        dreqwrite_i,
  input  logic [1:0]  dreqhpl_i,
  input  logic [31:0] dreqaddr_i,
  input  logic [31:0] dreqdata_i,
  input  logic        drspready_i,
  output logic        drspvalid_o,
  output logic        drsprerr_o,
  output logic        drspwerr_o,
  output logic [31:0] drspdata_o
);
  localparam int unsigned MEM_WORDS   = 1 << C_MEM_DEPTH_X;
  localparam int unsigned RSP_ENTRIES = 1 << C_RSP_DEPTH_X;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t                   r_state, w_state_nxt;
  logic [3:0]               r_cnt, w_cnt_nxt;
  logic [1:0]               r_size, r_hpl;
  logic                     r_write;
  logic [31:0]              r_addr, r_data;
  logic [31:0]              r_mem [MEM_WORDS];
  logic [33:0]              r_fifo [RSP_ENTRIES];
  logic [C_RSP_DEPTH_X-1:0] r_wp, r_rp;
  logic [C_RSP_DEPTH_X:0]   r_used;
  logic                     w_accept, w_access, w_pop, w_write, w_err, w_misalign, w_in_range, w_we;
  logic [1:0]               w_size, w_hpl;
  logic [31:0]              w_addr, w_data, w_off;
  logic [C_MEM_DEPTH_X-1:0] w_idx;
  logic [3:0]               w_be;
  logic [33:0]              w_rsp;
  assign dreqready_o = resetb_i && r_state == IDLE && r_used < (C_RSP_DEPTH_X+1)'(RSP_ENTRIES);
  assign w_accept    = clk_en_i && dreqvalid_i && dreqready_o;
  // Without wait states the access uses the live request on its accept edge
  assign w_access    = (C_WAIT_CYCLES == 0) ? w_accept : (clk_en_i && r_state == WAIT && r_cnt == 4'd1);
  assign w_size      = (C_WAIT_CYCLES == 0) ? dreqsize_i  : r_size;
  assign w_write     = (C_WAIT_CYCLES == 0) ? dreqwrite_i : r_write;
  assign w_hpl       = (C_WAIT_CYCLES == 0) ? dreqhpl_i   : r_hpl;
  assign w_addr      = (C_WAIT_CYCLES == 0) ? dreqaddr_i  : r_addr;
  assign w_data      = (C_WAIT_CYCLES == 0) ? dreqdata_i  : r_data;
  assign w_off       = w_addr - C_BASE_ADDR;
  assign w_in_range  = (w_off >> (C_MEM_DEPTH_X + 2)) == 32'd0;
  assign w_misalign  = (w_size == 2'd1 && w_addr[0]) || (w_size == 2'd2 && w_addr[1:0] != 2'b00);
  assign w_err       = w_size == 2'd3 || w_misalign || !w_in_range || (w_write && w_hpl == 2'b00 && !C_USER_WR_EN);
  assign w_idx       = w_off[C_MEM_DEPTH_X+1:2];
  assign w_be        = w_size == 2'd0 ? 4'b0001 << w_addr[1:0] : w_size == 2'd1 ? (w_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_we        = w_access && w_write && !w_err;
  assign w_rsp       = {!w_write && w_err, w_write && w_err, (!w_write && !w_err) ? r_mem[w_idx] : 32'h0};
  assign w_pop       = clk_en_i && drspvalid_o && drspready_i;
  assign drspvalid_o = r_used != '0;
  assign {drsprerr_o, drspwerr_o, drspdata_o} = drspvalid_o ? r_fifo[r_rp] : 34'h0;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state == IDLE && w_accept && C_WAIT_CYCLES != 0) begin
      w_state_nxt = WAIT;
      w_cnt_nxt   = 4'(C_WAIT_CYCLES);
    end else if (r_state == WAIT && clk_en_i) begin
      w_cnt_nxt   = r_cnt - 4'd1;
      w_state_nxt = r_cnt == 4'd1 ? IDLE : WAIT;
    end
  end
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_size  <= '0;
      r_write <= 1'b0;
      r_hpl   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_used  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_size  <= dreqsize_i;
        r_write <= dreqwrite_i;
        r_hpl   <= dreqhpl_i;
        r_addr  <= dreqaddr_i;
        r_data  <= dreqdata_i;
      end
      if (w_access) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_used <= r_used + (C_RSP_DEPTH_X+1)'(w_access) - (C_RSP_DEPTH_X+1)'(w_pop);
    end
  end
  // Storage arrays are not reset; all their write enables are already gated by reset
  always_ff @(posedge clk_i) begin
    if (w_access) r_fifo[r_wp] <= w_rsp;
    if (w_we)
      for (int k = 0; k < 4; k++)
        if (w_be[k]) r_mem[w_idx][8*k +: 8] <= w_data[8*k +: 8];
  end
endmodule

// File: doc/dport_sram_responder.md
DPORT_SRAM_RESPONDER -- requirements
Module: dport_sram_responder

Interface
REQ-001 SHALL have parameter C_MEM_DEPTH_X, default 8, meaning memory holds 2^C_MEM_DEPTH_X 32-bit words.
REQ-002 SHALL have parameter C_BASE_ADDR, default 32'h0, meaning the byte address of word 0 (aligned to the memory size).
REQ-003 SHALL have parameter C_WAIT_CYCLES, default 0, meaning extra cycles between request accept and memory access (range 0-15).
REQ-004 SHALL have parameter C_RSP_DEPTH_X, default 1, meaning response FIFO depth is 2^C_RSP_DEPTH_X entries.
REQ-005 SHALL have parameter C_USER_WR_EN, default 1, meaning 0 blocks writes issued at user privilege.
REQ-006 clk_i  in  1  clock; single clock domain; all state on rising edge.
REQ-007 resetb_i  in  1  reset, asynchronous, active-low.
REQ-008 clk_en_i  in  1  clock enable; when low, all state holds and no handshake completes.
REQ-009 dreqready_o  out  1  request can be accepted.
REQ-010 dreqvalid_i  in  1  request valid.
REQ-011 dreqsize_i  in  2  access size: 0 byte, 1 half, 2 word, 3 illegal.
REQ-012 dreqwrite_i  in  1  1 write, 0 read.
REQ-013 dreqhpl_i  in  2  hart privilege level (2'b00 user).
REQ-014 dreqaddr_i  in  32  byte address.
REQ-015 dreqdata_i  in  32  write data, lane-positioned (byte k of the word on bits 8k+7:8k).
REQ-016 drspready_i  in  1  initiator accepts response.
REQ-017 drspvalid_o  out  1  response valid.
REQ-018 drsprerr_o  out  1  read error.
REQ-019 drspwerr_o  out  1  write error.
REQ-020 drspdata_o  out  32  read data, full aligned word, lane-positioned.

Function
REQ-021 Request handshake SHALL complete on a rising edge with clk_en_i=1, dreqvalid_i=1 and dreqready_o=1; the block captures size, write, hpl, addr and data on that edge.
REQ-022 FSM SHALL have states IDLE and WAIT; dreqready_o=1 only in IDLE and only when the response FIFO holds fewer than 2^C_RSP_DEPTH_X entries.
REQ-023 With C_WAIT_CYCLES=0, the access SHALL occur on the accept edge and the FSM SHALL stay in IDLE.
REQ-024 With C_WAIT_CYCLES=N>0, accept SHALL move IDLE->WAIT and load a counter with N; the counter SHALL decrement on enabled cycles; at counter=1 the access SHALL occur and the FSM SHALL return to IDLE.
REQ-025 Each access SHALL push exactly one response entry {rerr, werr, data}; accept-to-drspvalid_o latency SHALL be 1+C_WAIT_CYCLES cycles when the FIFO is empty.
REQ-026 Error conditions: size=3; misalignment (half with addr[0]=1, word with addr[1:0]!=0); address outside [C_BASE_ADDR, C_BASE_ADDR+4*2^C_MEM_DEPTH_X); write with hpl=00 when C_USER_WR_EN=0.
REQ-027 Read OK: rerr=0, werr=0, data=word at (addr-C_BASE_ADDR)>>2.
REQ-028 Read error: rerr=1, werr=0, data=0.
REQ-029 Write OK: only the addressed byte lanes are updated (byte: 1 lane; half: lanes addr[1]*2 and addr[1]*2+1; word: all 4); rerr=0, werr=0, data=0.
REQ-030 Write error: memory SHALL NOT change; werr=1, rerr=0, data=0.
REQ-031 Response handshake SHALL complete on an enabled edge with drspvalid_o=1 and drspready_i=1; the FIFO pops on that edge, and outputs SHALL hold stable while drspready_i=0.
REQ-032 Simultaneous push and pop SHALL leave the entry count unchanged; responses SHALL be returned in request order.
REQ-033 When drspvalid_o=0, drsprerr_o, drspwerr_o and drspdata_o SHALL be 0.
REQ-034 A read following a write to the same word SHALL return the written data (no hazard), including back-to-back accesses with C_WAIT_CYCLES=0.

Reset
REQ-035 While resetb_i=0: dreqready_o=0, drspvalid_o=0, drsprerr_o=0, drspwerr_o=0, drspdata_o=0, FSM=IDLE, counter=0, FIFO empty.
REQ-036 Reset asserted mid-WAIT or with FIFO entries SHALL discard the pending access and all responses; memory contents are not reset and SHALL NOT be written by the discarded access.
REQ-037 On the first enabled cycle after reset release, dreqready_o SHALL be 1.

Verification
REQ-038 Word write 0xDEADBEEF @0x10, then word read @0x10, C_WAIT_CYCLES=0 -> both responses 1 cycle after accept; read data 0xDEADBEEF, no errors.
REQ-039 Byte write 0x0000AA00 size 0 @0x11 over 0x11223344 -> read @0x10 returns 0x1122AA44.
REQ-040 Half read @0x13, size 3 @0x0, and word write @0x400 (C_MEM_DEPTH_X=8) -> rerr=1/data 0, rerr=1, werr=1 in order; memory unchanged.
REQ-041 C_WAIT_CYCLES=3, drspready_i=0 with C_RSP_DEPTH_X=1 -> first drspvalid_o 4 cycles after accept; dreqready_o drops after 2 pending responses; then drspready_i=1 drains both in order.
REQ-042 C_USER_WR_EN=0, hpl=00 word write @0x20 -> werr=1, later read @0x20 returns prior value; same write with hpl=11 -> succeeds.
REQ-043 Reset pulse during WAIT, then clk_en_i=0 for 5 cycles with dreqvalid_i=1 -> no response; state frozen; no accept until clk_en_i=1.
